// File: rtl/fc_argmax_collector.sv
// Groups NUM_CLASSES logits per sample, takes a signed argmax and queues {class, max} in a FWFT FIFO.
// state      | meaning
// ST_COLLECT | accepting logits, producing one result per NUM_CLASSES logits
// ST_DONE    | NUM_SAMPLES results produced; logits ignored until reset/clear
module fc_argmax_collector #(
  parameter int DATA_W      = 36,
  parameter int NUM_CLASSES = 2,
  parameter int CLS_W       = 1,
  parameter int NUM_SAMPLES = 42,
  parameter int FIFO_DEPTH  = 64,
  parameter int CNT_W       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic [DATA_W-1:0]       logit_i,
  input  logic                    logit_vld_i,
  output logic                    pred_vld_o,
  output logic [CLS_W-1:0]        pred_cls_o,
  output logic [DATA_W-1:0]       pred_max_o,
  input  logic                    res_rd_i,
  output logic [CLS_W+DATA_W-1:0] res_data_o,
  output logic                    res_empty_o,
  output logic                    res_full_o,
  output logic                    overflow_o,
  output logic [CNT_W-1:0]        sample_cnt_o,
  output logic                    all_done_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int ENT_W  = CLS_W + DATA_W;

  typedef enum logic {ST_COLLECT = 1'b0, ST_DONE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CLS_W-1:0]    idx_q, idx_d, best_cls_q, best_cls_d, pred_cls_q, pred_cls_d, win_cls;
  logic [DATA_W-1:0]   best_q, best_d, pred_max_q, pred_max_d, win_max;
  logic                pred_vld_q, pred_vld_d, overflow_q, overflow_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic                logit_take, is_last, take_new;
  logic                fifo_empty, fifo_full, rd_ok, wr_en;

  // State register plus all datapath/control flops; clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      state_q      <= ST_COLLECT;
      idx_q        <= '0;
      best_q       <= '0;
      best_cls_q   <= '0;
      pred_vld_q   <= 1'b0;
      pred_cls_q   <= '0;
      pred_max_q   <= '0;
      sample_cnt_q <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_cls_q   <= best_cls_d;
      pred_vld_q   <= pred_vld_d;
      pred_cls_q   <= pred_cls_d;
      pred_max_q   <= pred_max_d;
      sample_cnt_q <= sample_cnt_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {pred_cls_q, pred_max_q};
  end

  // The first logit of a sample always wins; later ones need strictly greater, so ties keep the lower index.
  always_comb begin
    logit_take   = logit_vld_i && (state_q == ST_COLLECT);
    is_last      = (idx_q == CLS_W'(NUM_CLASSES - 1));
    take_new     = (idx_q == '0) || ($signed(logit_i) > $signed(best_q));
    win_max      = take_new ? logit_i : best_q;
    win_cls      = take_new ? idx_q : best_cls_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_cls_d   = best_cls_q;
    pred_vld_d   = 1'b0;
    pred_cls_d   = pred_cls_q;
    pred_max_d   = pred_max_q;
    sample_cnt_d = sample_cnt_q;
    if (logit_take) begin
      best_d     = win_max;
      best_cls_d = win_cls;
      idx_d      = is_last ? '0 : idx_q + CLS_W'(1);
      if (is_last) begin
        pred_vld_d = 1'b1;
        pred_cls_d = win_cls;
        pred_max_d = win_max;
        if (sample_cnt_q != CNT_W'(NUM_SAMPLES)) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_COLLECT) begin
      if (pred_vld_d && (sample_cnt_d == CNT_W'(NUM_SAMPLES))) state_d = ST_DONE;
    end
  end

  // A push into a full FIFO still lands if the head is popped in the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    rd_ok      = res_rd_i && !fifo_empty;
    wr_en      = pred_vld_q && (!fifo_full || rd_ok);
    rd_ptr_d   = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    overflow_d = overflow_q || (pred_vld_q && fifo_full && !rd_ok);
  end

  always_comb begin
    pred_vld_o   = pred_vld_q;
    pred_cls_o   = pred_cls_q;
    pred_max_o   = pred_max_q;
    res_data_o   = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    res_empty_o  = fifo_empty;
    res_full_o   = fifo_full;
    overflow_o   = overflow_q;
    sample_cnt_o = sample_cnt_q;
    all_done_o   = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor checks pulses, FIFO and flags.
module tb_fc_argmax_collector;
  localparam int DW = 36;
  localparam int CW = 1;
  localparam int NS = 42;
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  typedef logic [CW+DW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, vld, rd_a, rd_b;
  logic [DW-1:0] logit;
  logic pv_a, pv_b, empty_a, empty_b, full_a, full_b, ovf_a, ovf_b, done_a, done_b;
  logic [CW-1:0] pc_a, pc_b;
  logic [DW-1:0] pm_a, pm_b;
  ent_t rdata_a, rdata_b;
  logic [7:0] cnt_a, cnt_b;

  fc_argmax_collector u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .logit_i(logit), .logit_vld_i(vld),
    .pred_vld_o(pv_a), .pred_cls_o(pc_a), .pred_max_o(pm_a), .res_rd_i(rd_a),
    .res_data_o(rdata_a), .res_empty_o(empty_a), .res_full_o(full_a), .overflow_o(ovf_a),
    .sample_cnt_o(cnt_a), .all_done_o(done_a));

  fc_argmax_collector #(.FIFO_DEPTH(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .logit_i(logit), .logit_vld_i(vld),
    .pred_vld_o(pv_b), .pred_cls_o(pc_b), .pred_max_o(pm_b), .res_rd_i(rd_b),
    .res_data_o(rdata_b), .res_empty_o(empty_b), .res_full_o(full_b), .overflow_o(ovf_b),
    .sample_cnt_o(cnt_b), .all_done_o(done_b));

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  ent_t exp_q[$];
  ent_t ma[$];
  ent_t mb[$];
  bit ovf_ea = 1'b0;
  bit ovf_eb = 1'b0;
  int cnt_e  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    ent_t e;
    bit   have_e;
    if (mon_en) begin
      have_e = 1'b0;
      e      = '0;
      if (pv_a || pv_b) begin
        if (cnt_e < NS) cnt_e++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pred", {62'd0, pv_a, pv_b}, 64'd0);
        end else begin
          e      = exp_q.pop_front();
          have_e = 1'b1;
          chk("pred_vld_a", pv_a, 1);
          chk("pred_vld_b", pv_b, 1);
          chk("pred_a", {pc_a, pm_a}, e);
          chk("pred_b", {pc_b, pm_b}, e);
        end
      end
      chk("cnt_a", cnt_a, cnt_e);
      chk("cnt_b", cnt_b, cnt_e);
      chk("done_a", done_a, cnt_e == NS);
      chk("done_b", done_b, cnt_e == NS);
      chk("empty_a", empty_a, ma.size() == 0);
      chk("empty_b", empty_b, mb.size() == 0);
      chk("full_a", full_a, ma.size() == 64);
      chk("full_b", full_b, mb.size() == 4);
      chk("ovf_a", ovf_a, ovf_ea);
      chk("ovf_b", ovf_b, ovf_eb);
      if (!rst_n || clear) begin
        ma.delete();
        mb.delete();
        ovf_ea = 1'b0;
        ovf_eb = 1'b0;
        cnt_e  = 0;
      end else begin
        if (rd_a && ma.size() > 0) begin
          chk("rdata_a", rdata_a, ma[0]);
          void'(ma.pop_front());
        end
        if (rd_b && mb.size() > 0) begin
          chk("rdata_b", rdata_b, mb[0]);
          void'(mb.pop_front());
        end
        if (have_e) begin
          if (ma.size() < 64) ma.push_back(e); else ovf_ea = 1'b1;
          if (mb.size() < 4)  mb.push_back(e); else ovf_eb = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves logit_vld asserted so samples can follow back-to-back.
  task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input logic c, input logic signed [DW-1:0] m);
    exp_q.push_back({c, m});
    logit = a;
    vld   = 1'b1;
    tick();
    logit = b;
    tick();
  endtask

  task automatic drain();
    rd_a = 1'b1;
    rd_b = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (empty_a && empty_b) break;
      tick();
    end
    chk("drain_empty", {62'd0, empty_a, empty_b}, 64'd3);
    rd_a = 1'b0;
    rd_b = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    vld   = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; vld = 1'b0; logit = '0; rd_a = 1'b0; rd_b = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_pvld", pv_a, 0);
    chk("rst_cls", pc_a, 0);
    chk("rst_max", pm_a, 0);
    chk("rst_data", rdata_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;
    tick();

    // (+5,-3): one-cycle latency, then FWFT head
    send(36'sd5, -36'sd3, 1'b0, 36'sd5);
    vld = 1'b0;
    chk("t1_latency", pv_a, 1);
    tick();
    chk("t1_fwft_empty", empty_a, 0);
    chk("t1_fwft_data", rdata_a, {1'b0, 36'd5});

    // signed compare, tie, extremes
    send(-36'sd7, -36'sd2, 1'b1, -36'sd2);
    send(36'sd4, 36'sd4, 1'b0, 36'sd4);
    send(MINV, MAXV, 1'b1, MAXV);
    send(MAXV, MINV, 1'b0, MAXV);
    vld = 1'b0;
    idle(3);
    drain();

    // reads while empty are ignored
    rd_a = 1'b1;
    idle(3);
    rd_a = 1'b0;
    chk("t6_still_empty", empty_a, 1);
    send(36'sd10, 36'sd20, 1'b1, 36'sd20);
    send(-36'sd1, -36'sd5, 1'b0, -36'sd1);
    vld = 1'b0;
    idle(3);
    drain();

    // depth-4 instance: fifth result dropped
    do_reset();
    for (int k = 1; k <= 5; k++) send('0, DW'(k), 1'b1, DW'(k));
    vld = 1'b0;
    idle(2);
    chk("t4_full_b", full_b, 1);
    chk("t4_ovf_b", ovf_b, 1);
    chk("t4_ovf_a", ovf_a, 0);
    drain();

    // same, but pop on the fifth push cycle
    do_reset();
    for (int k = 1; k <= 5; k++) send('0, DW'(k), 1'b1, DW'(k));
    vld  = 1'b0;
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    idle(2);
    chk("t4r_ovf_b", ovf_b, 0);
    chk("t4r_full_b", full_b, 1);
    chk("t4r_head_b", rdata_b, {1'b1, 36'd2});
    drain();

    // reset mid-sample discards the partial sample
    do_reset();
    logit = 36'sd100;
    vld   = 1'b1;
    tick();
    vld   = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(36'sd1, 36'sd9, 1'b1, 36'sd9);
    vld = 1'b0;
    idle(2);
    chk("t5_rst_cnt", cnt_a, 1);

    // clear mid-sample behaves the same
    logit = 36'sd100;
    vld   = 1'b1;
    tick();
    vld   = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    send(36'sd1, 36'sd9, 1'b1, 36'sd9);
    vld = 1'b0;
    idle(2);
    chk("t5_clr_cnt", cnt_a, 1);
    chk("t5_clr_data", rdata_a, {1'b1, 36'd9});
    drain();

    // full run of 42 back-to-back samples, then logits in DONE are ignored
    do_reset();
    for (int i = 0; i < NS; i++) begin
      if (i % 2 == 0) send(DW'(3 * i), DW'(-i), 1'b0, DW'(3 * i));
      else            send(DW'(-i), DW'(1000 * i - 5), 1'b1, DW'(1000 * i - 5));
    end
    vld = 1'b0;
    idle(2);
    chk("t3_cnt", cnt_a, NS);
    chk("t3_done", done_a, 1);
    chk("t3_full_a", full_a, 0);
    logit = 36'sd7;
    vld   = 1'b1;
    tick();
    logit = 36'sd8;
    tick();
    logit = 36'sd9;
    tick();
    vld = 1'b0;
    idle(3);
    chk("t3_done_cnt", cnt_a, NS);
    chk("t3_done_lvl", done_a, 1);
    drain();

    chk("pending_preds", exp_q.size(), 0);
    chk("model_a_left", ma.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
